// File: rtl/rs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rs_pkg                                                  |
// | Description : Shared types and constants for the result streamer.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package rs_pkg;

  localparam int unsigned IMG_W_DEF   = 128;
  localparam int unsigned IMG_H_DEF   = 128;
  localparam int unsigned PIX_CNT_DEF = IMG_W_DEF * IMG_H_DEF;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CSUM_W = 24;

  // Readout sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rs_state_e;

  // One buffered pixel: value plus end-of-frame marker
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rs_pix_t;

  // Number of pixels in a frame of the given geometry
  function automatic int unsigned pix_count(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rs_skid_fifo                                            |
// | Description : Two-entry FIFO holding pixel data plus last flag.      |
// |               Head is presented combinationally and only moves on a  |
// |               pop, so the output is stable while the sink stalls.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module rs_skid_fifo
  import rs_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic [1:0]        count_o
);

  rs_pix_t    mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok;
  logic       pop_ok;

  // Writes into a full FIFO and reads from an empty one are dropped
  assign push_ok = push_i && (count_q != 2'd2);
  assign pop_ok  = pop_i  && (count_q != 2'd0);

  assign data_o  = mem_q[rd_ptr_q].data;
  assign last_o  = mem_q[rd_ptr_q].last;
  assign count_o = count_q;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; storage cleared so the idle head reads 0
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {last_i, data_i};
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : result_streamer                                        |
// | Description : Reads a finished result image out of memory and        |
// |               streams it over a valid/ready interface, keeping a     |
// |               running checksum of the accepted pixels.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module result_streamer
  import rs_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              eng_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CSUM_W-1:0] checksum
);

  localparam int unsigned       NPIX      = pix_count(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  rs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic              eng_busy_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              ren_d;

  logic              trigger;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [2:0]        pending;

  // A start pulse and an engine busy->idle edge collapse into one trigger
  assign trigger = start || (eng_busy_q && !eng_busy);

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Pixels that will still be buffered after this cycle's pop; a new read
  // is only issued if it is guaranteed a FIFO slot when its data lands
  assign pending = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  assign mem_ren  = ren_d;
  assign mem_addr = addr_q;
  assign busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign checksum = csum_q;

  rs_skid_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .data_i  (mem_data),
    .last_i  (inflight_last_q),
    .pop_i   (pop),
    .data_o  (out_data),
    .last_o  (out_last),
    .count_o (fifo_count)
  );

  // Next-state, read issue and checksum accumulation
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    ren_d   = 1'b0;

    if (pop) begin
      csum_d = csum_q + {{(CSUM_W-DATA_W){1'b0}}, out_data};
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_READ;
          addr_d  = '0;
          csum_d  = '0;
        end
      end
      ST_READ: begin
        if (pending < 3'd2) begin
          ren_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, edge detector and read-in-flight tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      csum_q          <= '0;
      eng_busy_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      csum_q          <= csum_d;
      eng_busy_q      <= eng_busy;
      inflight_q      <= ren_d;
      inflight_last_q <= ren_d && (addr_q == LAST_ADDR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_result_streamer                                     |
// | Description : Directed testbench with read-address scoreboard for    |
// |               result_streamer.                                       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_result_streamer;
  import rs_pkg::*;

  localparam int NPIX = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        eng_busy = 1'b0;
  logic [13:0] mem_addr;
  logic        mem_ren;
  logic [7:0]  mem_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [23:0] checksum;

  result_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .eng_busy  (eng_busy),
    .mem_addr  (mem_addr),
    .mem_ren   (mem_ren),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 0 -> data is low address byte, 1 -> all 0xFF
  int mem_mode = 0;
  always @(posedge clk) begin
    if (mem_ren) mem_data <= (mem_mode == 1) ? 8'hFF : mem_addr[7:0];
  end

  function automatic logic [7:0] exp_pix(input int a);
    logic [31:0] av;
    av = a;
    return (mem_mode == 1) ? 8'hFF : av[7:0];
  endfunction

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard state
  logic [8:0]  sbq[$];
  int          exp_addr = 0;
  int          pix_cnt = 0;
  int          done_cnt = 0;
  logic [23:0] model_sum = 24'd0;
  int          read_start_cyc = -1;
  int          first_valid_cyc = -1;
  int          done_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        prev_last = 1'b0;
  logic        prev_busy = 1'b0;

  // Monitor: expected pixels queued on each read, compared on each pop
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (busy && !prev_busy) read_start_cyc = cyc;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("pix_data", out_data, e[7:0]);
          chk("pix_last", out_last, e[8]);
          model_sum = model_sum + {16'd0, e[7:0]};
          pix_cnt++;
        end
      end
      if (mem_ren) begin
        chk("rd_addr", mem_addr, exp_addr);
        sbq.push_back({(exp_addr == NPIX - 1), exp_pix(exp_addr)});
        exp_addr++;
      end
      chk("no_overflow", sbq.size() <= 2, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        chk("busy_before_done", prev_busy, 1);
        chk("pix_count", pix_cnt, NPIX);
        chk("checksum_model", checksum, model_sum);
        chk("sb_empty_at_done", sbq.size(), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_busy  = busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_clear();
    sbq.delete();
    exp_addr        = 0;
    pix_cnt         = 0;
    model_sum       = 24'd0;
    read_start_cyc  = -1;
    first_valid_cyc = -1;
    done_cyc        = -1;
  endtask

  task automatic check_reset_outs();
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_checksum", checksum, 0);
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      step();
      n++;
    end
    chk("done_timeout", done_cnt != base, 1);
  endtask

  initial begin
    int base;
    int fall_cyc;
    int n;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check_reset_outs();
    reset = 1'b0;
    step();

    // Readout aborted by reset at pixel 5000
    mem_mode  = 0;
    out_ready = 1'b1;
    sb_clear();
    base  = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (pix_cnt < 5000 && n < 10000) begin
      step();
      n++;
    end
    chk("reach_pix5000", pix_cnt >= 5000, 1);
    reset = 1'b1;
    step();
    check_reset_outs();
    reset = 1'b0;
    repeat (20) step();
    chk("abort_no_done", done_cnt, base);
    chk("abort_idle", busy, 0);

    // Full readout after the abort, start pulse, ready held high
    sb_clear();
    base  = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(base, 20000);
    chk("B_checksum", checksum, 2088960);
    repeat (5) step();
    chk("B_checksum_hold", checksum, 2088960);
    chk("B_one_done", done_cnt, base + 1);
    chk("B_idle", busy, 0);

    // Engine-busy falling edge trigger, all-0xFF memory, late triggers ignored
    mem_mode = 1;
    sb_clear();
    base     = done_cnt;
    eng_busy = 1'b1;
    repeat (100) step();
    chk("C_no_early_start", busy, 0);
    eng_busy = 1'b0;
    fall_cyc = cyc;
    repeat (50) step();
    eng_busy = 1'b1;
    step();
    eng_busy = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_done(base, 20000);
    chk("C_trigger_latency", read_start_cyc - fall_cyc, 1);
    chk("C_first_valid_latency", first_valid_cyc - read_start_cyc, 2);
    chk("C_done_latency", done_cyc - read_start_cyc, 16386);
    chk("C_checksum", checksum, 4177920);
    repeat (10) step();
    chk("C_one_done", done_cnt, base + 1);
    chk("C_no_retrigger", busy, 0);

    // Simultaneous start and falling edge, random backpressure
    mem_mode = 0;
    sb_clear();
    base     = done_cnt;
    eng_busy = 1'b1;
    step();
    eng_busy = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done_cnt == base && n < 60000) begin
      out_ready = ($urandom_range(0, 1) == 1);
      step();
      n++;
    end
    chk("D_done_seen", done_cnt != base, 1);
    out_ready = 1'b1;
    chk("D_checksum", checksum, 2088960);
    repeat (10) step();
    chk("D_one_done", done_cnt, base + 1);
    chk("D_no_second_readout", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 128, meaning image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 128, meaning image height in pixels.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: manual trigger pulse.
REQ-006 The block SHALL have port eng_busy, input, 1 bit: the busy output of the filter engine that writes result memory.
REQ-007 The block SHALL have port mem_addr, output, 14 bits: result-memory read address.
REQ-008 The block SHALL have port mem_ren, output, 1 bit: read enable.
REQ-009 The block SHALL have port mem_data, input, 8 bits: read data, valid exactly one cycle after a mem_ren cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the output stream handshake.
REQ-011 The block SHALL have port out_data, output, 8 bits: the pixel value.
REQ-012 The block SHALL have port out_last, output, 1 bit: marks pixel IMG_W*IMG_H-1.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a readout is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port checksum, output, 24 bits: sum modulo 2^24 of the pixels accepted in the current or last readout.

Function
REQ-016 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-017 In IDLE, a trigger SHALL move the FSM to READ; a trigger is start=1 or a falling edge of eng_busy (registered previous value 1, current value 0).
REQ-018 A start and an eng_busy falling edge in the same cycle SHALL produce exactly one readout.
REQ-019 Triggers arriving outside IDLE SHALL be ignored.
REQ-020 On entry to READ, the read address counter and checksum SHALL be cleared to 0.
REQ-021 In READ, mem_ren SHALL assert with mem_addr equal to the counter whenever (FIFO occupancy + in-flight reads − pop this cycle) < 2.
REQ-022 Each mem_ren SHALL increment the address counter; the address issued runs 0 to IMG_W*IMG_H-1 without wrap.
REQ-023 mem_data SHALL be written into a 2-entry FIFO on the cycle after mem_ren.
REQ-024 After issuing the last address, the FSM SHALL go to DRAIN, and issue no further reads.
REQ-025 out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head.
REQ-026 A pop SHALL occur when out_valid and out_ready are both high.
REQ-027 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 Latency: the first out_valid SHALL assert 2 cycles after the first READ cycle.
REQ-029 With out_ready held high, throughput SHALL be 1 pixel per cycle.
REQ-030 On each pop, checksum SHALL add out_data, zero-extended to 24 bits, with wrap modulo 2^24.
REQ-031 In DRAIN, when the popped pixel carries out_last, the FSM SHALL go to DONE.
REQ-032 In DONE, done=1 for one cycle; the FSM then returns to IDLE.
REQ-033 busy SHALL be 1 in READ and DRAIN, and 0 otherwise.
REQ-034 checksum SHALL hold its value in IDLE until the next trigger.

Reset
REQ-035 While reset=1 at a clock edge: state←IDLE, the FIFO is empty, the counters are 0, and the registered eng_busy is 0.
REQ-036 While reset=1 at a clock edge: mem_ren, out_valid, out_last, busy and done are all 0; mem_addr=0, out_data=0, checksum=0.
REQ-037 Reset during READ or DRAIN SHALL abort the readout; no done pulse SHALL be produced, and in-flight read data SHALL be discarded.

Structure
REQ-038 The state encoding, IMG_W/IMG_H defaults and pixel-count constant SHALL live in the shared package rs_pkg.
REQ-039 The 2-entry FIFO SHALL be the sub-module rs_skid_fifo (8-bit data plus last bit, with push, pop, count, and synchronous reset).

Verification
REQ-040 Memory model returns mem_data=addr[7:0]; pulse start once, out_ready=1 -> 16384 pixels in order, out_last only on pixel 16383, done pulses once, checksum=2,088,960, busy drops with done.
REQ-041 eng_busy held 1 for 100 cycles then 0 -> readout begins exactly 1 cycle after the falling edge; eng_busy rising while busy -> no effect.
REQ-042 out_ready toggled randomly (~50%) -> data order and checksum identical to REQ-040; out_data stable while stalled; mem_ren never causes FIFO overflow.
REQ-043 start and eng_busy falling edge in the same cycle -> exactly one readout and one done pulse.
REQ-044 reset asserted at pixel 5000 -> next cycle all outputs at reset values, no done pulse; start then -> complete correct readout beginning at address 0.
REQ-045 All-0xFF memory with out_ready=1 -> checksum=4,177,920, first out_valid 2 cycles after READ entry, done pulse 16386 cycles after READ entry.
